// File: rtl/udp_audio_depacker.sv
// udp_audio_depacker: rebuilds 16-bit audio samples (high byte first) from UDP payload bytes into a datagram-committed circular buffer
//   rgmii_clk, rstn                  clock, synchronous active-low reset
//   rx_valid, rx_data, rx_length     payload byte stream and its announced byte count
//   sample_req                       request for the next playback sample
//   sample_out, sample_valid         sample and its strobe, one cycle after the request
//   level                            committed samples held in the buffer
//   frame_ok, frame_drop, underrun   status pulses
module udp_audio_depacker #(
  parameter int DEPTH_LOG2 = 11,
  parameter int MAX_FRAME_BYTES = 1024,
  parameter int PREFILL = 480
) (
  input  logic                  rgmii_clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [15:0]           rx_length,
  input  logic                  sample_req,
  output logic [15:0]           sample_out,
  output logic                  sample_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  frame_ok,
  output logic                  frame_drop,
  output logic                  underrun
);
  localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  typedef enum logic [1:0] {R_IDLE, R_RECV, R_DROP} rx_state_t;
  typedef enum logic {P_FILL, P_PLAY} play_state_t;
  rx_state_t rx_state;
  play_state_t play_state;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_tmp, free;
  logic [15:0] len, byte_cnt;
  logic [7:0] hi;
  logic bad, rx_valid_d, rise, len_ok, in_frame, we;
  assign level = wr_ptr - rd_ptr;
  assign free = CAP - level;
  assign rise = rx_valid & ~rx_valid_d;
  assign len_ok = rx_length != 16'd0 && !rx_length[0] && rx_length <= 16'(MAX_FRAME_BYTES)
                  && {1'b0, rx_length[15:1]} <= 16'(free);
  assign in_frame = rx_state == R_RECV && rx_valid && byte_cnt < len;
  // once a frame is bad nothing more is written, so a runaway stream can never reach committed data
  assign we = in_frame && byte_cnt[0] && !bad;
  // unreset on purpose: tracking rx_valid through reset makes a frame already in flight look like no rising edge
  always_ff @(posedge rgmii_clk) rx_valid_d <= rx_valid;
  always_ff @(posedge rgmii_clk) if (we) mem[wr_tmp[DEPTH_LOG2-1:0]] <= {hi, rx_data};
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      rx_state <= R_IDLE;
      wr_ptr <= '0;
      wr_tmp <= '0;
      len <= '0;
      byte_cnt <= '0;
      hi <= '0;
      bad <= 1'b0;
      frame_ok <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      frame_drop <= 1'b0;
      case (rx_state)
        R_IDLE: if (rx_valid) begin
          len <= rx_length;
          hi <= rx_data;
          byte_cnt <= 16'd1;
          bad <= 1'b0;
          rx_state <= rise && len_ok ? R_RECV : R_DROP;
        end
        R_RECV: if (rx_valid) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (!in_frame) bad <= 1'b1;
          else if (!byte_cnt[0]) hi <= rx_data;
          if (we) wr_tmp <= wr_tmp + ONE;
        end else begin
          if (byte_cnt == len && !bad) begin
            wr_ptr <= wr_tmp;
            frame_ok <= 1'b1;
          end else begin
            wr_tmp <= wr_ptr;
            frame_drop <= 1'b1;
          end
          rx_state <= R_IDLE;
        end
        R_DROP: if (!rx_valid) begin
          frame_drop <= 1'b1;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      play_state <= P_FILL;
      rd_ptr <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      underrun <= 1'b0;
      if (play_state == P_FILL) begin
        if (sample_req) sample_out <= '0;
        if (level >= (DEPTH_LOG2+1)'(PREFILL)) play_state <= P_PLAY;
      end else if (sample_req) begin
        if (level != '0) begin
          sample_out <= mem[rd_ptr[DEPTH_LOG2-1:0]];
          rd_ptr <= rd_ptr + ONE;
        end else begin
          sample_out <= '0;
          underrun <= 1'b1;
          play_state <= P_FILL;
        end
      end
    end
  end
endmodule

// File: tb/tb_udp_audio_depacker.sv
// tb_udp_audio_depacker: scoreboard bench for the UDP audio depacker
module tb_udp_audio_depacker;
  localparam int PREFILL = 480;
  logic clk = 0, rstn = 0, rx_valid = 0, sample_req = 0;
  logic [7:0] rx_data = 0;
  logic [15:0] rx_length = 0;
  logic [15:0] sample_out;
  logic sample_valid, frame_ok, frame_drop, underrun;
  logic [11:0] level;
  int errors = 0, checks = 0;
  logic [15:0] mq[$];
  logic [16:0] exp_q[$];
  logic [7:0] nb = 0;
  bit m_play = 0;
  logic req_d = 0;
  always #4 clk = ~clk;
  udp_audio_depacker dut (
    .rgmii_clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_length(rx_length),
    .sample_req(sample_req), .sample_out(sample_out), .sample_valid(sample_valid), .level(level),
    .frame_ok(frame_ok), .frame_drop(frame_drop), .underrun(underrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    logic [16:0] e;
    if (sample_valid || req_d) begin
      check("valid_latency", 32'(sample_valid), 32'(req_d));
      if (sample_valid) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 17'h1ffff;
        check("sample", 32'({underrun, sample_out}), 32'(e));
      end
    end
    req_d = sample_req;
  end
  task automatic send(input int len, input int n, input bit ok, input int rst_at = -10);
    logic [15:0] s[$];
    logic [7:0] h = 0;
    rx_length = 16'(len);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1;
      rx_data = nb;
      if (i[0]) s.push_back({h, nb});
      else h = nb;
      rstn = !(i >= rst_at && i < rst_at + 3);
      if (i == rst_at) begin
        mq.delete();
        m_play = 0;
      end
      nb++;
      tick;
    end
    rstn = 1;
    rx_valid = 0;
    tick;
    check("frame_ok", 32'(frame_ok), 32'(ok));
    check("frame_drop", 32'(frame_drop), 32'(!ok));
    if (ok) mq = {mq, s};
    check("level", 32'(level), mq.size());
    tick;
    check("status_pulse", 32'({frame_ok, frame_drop}), 0);
  endtask
  task automatic req(input int n);
    for (int i = 0; i < n; i++) begin
      sample_req = 1;
      if (!m_play && mq.size() >= PREFILL) m_play = 1;
      if (!m_play) exp_q.push_back(17'h0);
      else if (mq.size() > 0) exp_q.push_back({1'b0, mq.pop_front()});
      else begin
        exp_q.push_back(17'h10000);
        m_play = 0;
      end
      tick;
    end
    sample_req = 0;
    repeat (3) tick;
    check("sb_drain", exp_q.size(), 0);
  endtask
  initial begin
    repeat (4) tick;
    rstn = 1;
    tick;
    check("rst_level", 32'(level), 0);
    check("rst_sample", 32'(sample_out), 0);
    check("rst_flags", 32'({sample_valid, frame_ok, frame_drop, underrun}), 0);
    send(240, 240, 1);
    req(3);
    for (int k = 0; k < 4; k++) send(240, 240, 1);
    check("level_600", 32'(level), 600);
    req(10);
    send(240, 238, 0);
    send(240, 240, 1);
    send(241, 241, 0);
    send(0, 4, 0);
    send(1026, 1026, 0);
    check("level_710", 32'(level), 710);
    send(1024, 1024, 1);
    send(1024, 1024, 1);
    send(532, 532, 1);
    check("level_2000", 32'(level), 2000);
    send(240, 240, 0);
    req(100);
    send(240, 240, 1);
    check("level_2020", 32'(level), 2020);
    req(2022);
    send(240, 240, 1);
    send(240, 240, 0, 100);
    check("level_after_rst", 32'(level), 0);
    send(240, 240, 1);
    req(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
